// File: rtl/vrf_bram_rd_streamer.sv
// Burst read streamer in front of a registered-output block RAM port (read latency 2).
// Optional VRF_RD_STRIDE_EN adds a per-request address stride; default build uses stride 1.
module vrf_bram_rd_streamer #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 512,
   parameter int LEN_W      = 10,
   parameter int FIFO_DEPTH = 4,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [AW-1:0]    req_addr_i,
`ifdef VRF_RD_STRIDE_EN
   input  logic [AW-1:0]    req_stride_i,
`endif
   input  logic [LEN_W-1:0] req_len_i,
   output logic             busy_o,
   output logic [AW-1:0]    bram_addr_o,
   output logic             bram_en_o,
   output logic             bram_oreg_en_o,
   output logic             bram_rst_o,
   input  logic [WIDTH-1:0] bram_dout_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             dout_valid_o,
   input  logic             dout_ready_i,
   output logic             dout_last_o,
   output logic             done_o
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
   localparam logic [CW:0]   CREDITS  = (CW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           state_reg, state_next;
   logic [AW-1:0]    addr_reg;
   logic [LEN_W-1:0] remaining_reg;
   logic [AW-1:0]    stride;
   logic [1:0]       pipe_vld_reg, pipe_last_reg;
   logic [WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];
   logic             fifo_last_mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             bram_rst_reg;

   logic             req_fire, issue, issue_last;
   logic             push, pop, last_pop, fifo_empty, fifo_full;
   logic [CW:0]      outstanding;
   logic [AW:0]      addr_sum;
   logic [AW-1:0]    addr_step;

`ifdef VRF_RD_STRIDE_EN
   logic [AW-1:0]    stride_reg;
   assign stride = stride_reg;
`else
   assign stride = AW'(1);
`endif

   // Credits count words already buffered plus words still inside the RAM pipe.
   assign outstanding = {1'b0, count_reg} + (CW+1)'(pipe_vld_reg[0]) + (CW+1)'(pipe_vld_reg[1]);
   assign req_fire    = (state_reg == S_IDLE) && req_valid_i;
   assign issue       = (state_reg == S_RUN) && (outstanding < CREDITS);
   assign issue_last  = issue && (remaining_reg == LEN_W'(1));
   assign push        = pipe_vld_reg[1];
   assign fifo_empty  = (count_reg == '0);
   assign fifo_full   = (count_reg == CW'(FIFO_DEPTH));
   assign pop         = !fifo_empty && dout_ready_i;
   assign last_pop    = pop && fifo_last_mem[rd_ptr_reg];

   // Modulo-DEPTH advance; a stride is assumed to be below DEPTH.
   assign addr_sum  = {1'b0, addr_reg} + {1'b0, stride};
   assign addr_step = (addr_sum >= DEPTH_W) ? AW'(addr_sum - DEPTH_W) : addr_sum[AW-1:0];

   always_ff @(posedge clk) begin
      if (!rstn) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // An empty burst passes through DRAIN, which exits at once with nothing outstanding.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (req_valid_i) state_next = (req_len_i == '0) ? S_DRAIN : S_RUN;
         S_RUN:   if (issue_last) state_next = S_DRAIN;
         S_DRAIN: if (last_pop || (outstanding == '0)) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = 1'b0;
      busy_o      = 1'b1;
      bram_en_o   = 1'b0;
      done_o      = 1'b0;
      case (state_reg)
         S_IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
         end
         S_RUN:   bram_en_o = issue;
         S_DONE:  done_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr_reg      <= '0;
         remaining_reg <= '0;
         pipe_vld_reg  <= '0;
         pipe_last_reg <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
`ifdef VRF_RD_STRIDE_EN
         stride_reg    <= '0;
`endif
      end else begin
         if (req_fire) begin
            addr_reg      <= req_addr_i;
            remaining_reg <= req_len_i;
`ifdef VRF_RD_STRIDE_EN
            stride_reg    <= req_stride_i;
`endif
         end else if (issue) begin
            addr_reg      <= addr_step;
            remaining_reg <= remaining_reg - LEN_W'(1);
         end
         pipe_vld_reg  <= {pipe_vld_reg[0], issue};
         pipe_last_reg <= {pipe_last_reg[0], issue_last};
         if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_mem[wr_ptr_reg] <= bram_dout_i;
         fifo_last_mem[wr_ptr_reg] <= pipe_last_reg[1];
      end
   end

   always_ff @(posedge clk) begin
      bram_rst_reg <= ~rstn;
   end

   assign bram_addr_o    = addr_reg;
   assign bram_oreg_en_o = 1'b1;
   assign bram_rst_o     = bram_rst_reg;
   assign dout_valid_o   = !fifo_empty;
   assign dout_o         = fifo_empty ? '0 : fifo_data_mem[rd_ptr_reg];
   assign dout_last_o    = !fifo_empty && fifo_last_mem[rd_ptr_reg];

   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && fifo_full));

endmodule

// File: tb/tb_vrf_bram_rd_streamer.sv
// Directed bench for vrf_bram_rd_streamer with a latency-2 registered-output RAM model.
// Stride scenario is compiled in only when VRF_RD_STRIDE_EN is defined.
module tb_vrf_bram_rd_streamer;

   localparam int WIDTH = 32;
   localparam int DEPTH = 512;
   localparam int LEN_W = 10;
   localparam int AW    = 9;

   logic             clk = 1'b0;
   logic             rstn;
   logic             req_valid;
   logic             req_ready;
   logic [AW-1:0]    req_addr;
   logic [LEN_W-1:0] req_len;
   logic             busy;
   logic [AW-1:0]    bram_addr;
   logic             bram_en, bram_oreg_en, bram_rst;
   logic [WIDTH-1:0] bram_dout;
   logic [WIDTH-1:0] dout;
   logic             dout_valid, dout_ready, dout_last, done;
`ifdef VRF_RD_STRIDE_EN
   logic [AW-1:0]    req_stride;
`endif

   int checks = 0;
   int errors = 0;

   int words[$];
   int lasts[$];
   int pop_cyc[$];
   int iss_addr[$];
   int iss_cyc[$];
   int done_cyc, first_valid_cyc, n_valid_cyc, max_out;
   bit busy_c1, ready_c1, timed_out, aborted;

   logic [WIDTH-1:0] ram [DEPTH];
   logic [WIDTH-1:0] ram_lat;

   always #5 clk = ~clk;

   vrf_bram_rd_streamer #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .LEN_W(LEN_W), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .req_valid_i(req_valid),
      .req_ready_o(req_ready),
      .req_addr_i(req_addr),
`ifdef VRF_RD_STRIDE_EN
      .req_stride_i(req_stride),
`endif
      .req_len_i(req_len),
      .busy_o(busy),
      .bram_addr_o(bram_addr),
      .bram_en_o(bram_en),
      .bram_oreg_en_o(bram_oreg_en),
      .bram_rst_o(bram_rst),
      .bram_dout_i(bram_dout),
      .dout_o(dout),
      .dout_valid_o(dout_valid),
      .dout_ready_i(dout_ready),
      .dout_last_o(dout_last),
      .done_o(done)
   );

   // RAM model: array latch on enable, then output register (2-cycle latency).
   always @(posedge clk) begin
      if (bram_en) ram_lat <= ram[bram_addr];
      if (bram_rst) bram_dout <= '0;
      else if (bram_oreg_en) bram_dout <= ram_lat;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Handshake happens in cycle 0; per-cycle activity is recorded relative to it.
   task automatic run_burst(input int addr, input int len, input int stride,
                            input int lo, input int hi, input int abort_pops);
      int n_iss = 0;
      int n_pop = 0;
      words.delete(); lasts.delete(); pop_cyc.delete(); iss_addr.delete(); iss_cyc.delete();
      done_cyc = -1; first_valid_cyc = -1; n_valid_cyc = 0; max_out = 0;
      timed_out = 0; aborted = 0;
      req_valid  = 1'b1;
      req_addr   = AW'(addr);
      req_len    = LEN_W'(len);
`ifdef VRF_RD_STRIDE_EN
      req_stride = AW'(stride);
`else
      if (stride != 1) $display("note: stride %0d ignored in this build", stride);
`endif
      dout_ready = 1'b1;
      step();
      req_valid = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         dout_ready = !(c >= lo && c <= hi);
         if (c == 1) begin busy_c1 = busy; ready_c1 = req_ready; end
         if (bram_en) begin iss_addr.push_back(int'(bram_addr)); iss_cyc.push_back(c); n_iss++; end
         if (n_iss - n_pop > max_out) max_out = n_iss - n_pop;
         if (dout_valid) begin
            n_valid_cyc++;
            if (first_valid_cyc < 0) first_valid_cyc = c;
         end
         if (dout_valid && dout_ready) begin
            words.push_back(int'(dout)); lasts.push_back(int'(dout_last)); pop_cyc.push_back(c);
            n_pop++;
            $display("cycle %0d word %0d last %0b", c, dout, dout_last);
         end
         if (done) begin done_cyc = c; break; end
         if (abort_pops != 0 && n_pop == abort_pops) begin aborted = 1; break; end
         step();
      end
      dout_ready = 1'b1;
      if (done_cyc >= 0) step();
      else if (!aborted) timed_out = 1;
   endtask

   task automatic test_reset();
      logic [7:0] obs;
      rstn = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; dout_ready = 1'b1;
`ifdef VRF_RD_STRIDE_EN
      req_stride = '0;
`endif
      step(); step();
      obs = {req_ready, busy, bram_en, dout_valid, dout_last, done, bram_oreg_en, bram_rst};
      checks++;
      if (obs !== 8'b1000_0011) begin errors++; $display("FAIL reset_outputs got %b exp 10000011", obs); end
      checks++;
      if (dout !== '0 || bram_addr !== '0) begin
         errors++; $display("FAIL reset_data got dout %0d addr %0d exp 0 0", dout, bram_addr);
      end
      rstn = 1'b1;
      step();
      checks++;
      if (bram_rst !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release got rst %0b ready %0b exp 0 1", bram_rst, req_ready);
      end
   endtask

   task automatic test_basic();
      run_burst(10, 4, 1, 0, -1, 0);
      checks++;
      if (timed_out || done_cyc !== 8) begin errors++; $display("FAIL basic_done got cycle %0d exp 8", done_cyc); end
      checks++;
      if ({busy_c1, ready_c1} !== 2'b10) begin
         errors++; $display("FAIL basic_busy got busy %0b ready %0b exp 1 0", busy_c1, ready_c1);
      end
      checks++;
      if (first_valid_cyc !== 4) begin errors++; $display("FAIL basic_first_valid got %0d exp 4", first_valid_cyc); end
      checks++;
      if (words.size() !== 4 || iss_addr.size() !== 4) begin
         errors++; $display("FAIL basic_counts got words %0d issues %0d exp 4 4", words.size(), iss_addr.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= words.size() || words[i] !== 110 + i || pop_cyc[i] !== 4 + i || lasts[i] !== int'(i == 3)) begin
            errors++;
            $display("FAIL basic_word[%0d] got %0d cyc %0d last %0d exp %0d cyc %0d last %0d",
                     i, words[i], pop_cyc[i], lasts[i], 110 + i, 4 + i, int'(i == 3));
         end
         checks++;
         if (i >= iss_addr.size() || iss_addr[i] !== 10 + i || iss_cyc[i] !== 1 + i) begin
            errors++;
            $display("FAIL basic_issue[%0d] got addr %0d cyc %0d exp %0d cyc %0d", i, iss_addr[i], iss_cyc[i], 10 + i, 1 + i);
         end
      end
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_idle got ready %0b busy %0b exp 1 0", req_ready, busy);
      end
   endtask

   task automatic test_backpressure();
      run_burst(10, 8, 1, 5, 9, 0);
      checks++;
      if (timed_out) begin errors++; $display("FAIL bp_timeout got no done exp done"); end
      checks++;
      if (words.size() !== 8 || iss_addr.size() !== 8) begin
         errors++; $display("FAIL bp_counts got words %0d issues %0d exp 8 8", words.size(), iss_addr.size());
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= words.size() || words[i] !== 110 + i || lasts[i] !== int'(i == 7)) begin
            errors++; $display("FAIL bp_word[%0d] got %0d last %0d exp %0d last %0d", i, words[i], lasts[i], 110 + i, int'(i == 7));
         end
      end
      checks++;
      if (max_out !== 4) begin errors++; $display("FAIL bp_max_outstanding got %0d exp 4", max_out); end
      checks++;
      if (iss_cyc.size() < 6 || iss_cyc[4] !== 5 || iss_cyc[5] !== 11) begin
         errors++; $display("FAIL bp_issue_gap got 5th %0d 6th %0d exp 5 11", iss_cyc[4], iss_cyc[5]);
      end
   endtask

   task automatic test_wrap();
      int exp_a[4];
      exp_a = '{510, 511, 0, 1};
      run_burst(510, 4, 1, 0, -1, 0);
      checks++;
      if (timed_out || words.size() !== 4) begin
         errors++; $display("FAIL wrap_count got %0d words exp 4", words.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= iss_addr.size() || iss_addr[i] !== exp_a[i] || words[i] !== exp_a[i] + 100) begin
            errors++;
            $display("FAIL wrap[%0d] got addr %0d word %0d exp addr %0d word %0d", i, iss_addr[i], words[i], exp_a[i], exp_a[i] + 100);
         end
      end
   endtask

   task automatic test_zero_len();
      run_burst(7, 0, 1, 0, -1, 0);
      checks++;
      if (timed_out || done_cyc !== 2) begin errors++; $display("FAIL zero_done got cycle %0d exp 2", done_cyc); end
      checks++;
      if (iss_addr.size() !== 0 || n_valid_cyc !== 0) begin
         errors++; $display("FAIL zero_activity got issues %0d valid %0d exp 0 0", iss_addr.size(), n_valid_cyc);
      end
      checks++;
      if (ready_c1 !== 1'b0) begin errors++; $display("FAIL zero_accept got ready %0b exp 0", ready_c1); end
   endtask

   task automatic test_reset_mid_burst();
      logic [7:0] obs;
      int quiet;
      run_burst(10, 8, 1, 0, -1, 3);
      checks++;
      if (!aborted || words.size() !== 3 || words[2] !== 112) begin
         errors++; $display("FAIL midrst_pre got %0d words last %0d exp 3 words last 112", words.size(), words[2]);
      end
      step();
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      obs = {req_ready, busy, bram_en, dout_valid, dout_last, done, bram_oreg_en, bram_rst};
      checks++;
      if (obs !== 8'b1000_0011 || dout !== '0) begin
         errors++; $display("FAIL midrst_outputs got %b dout %0d exp 10000011 dout 0", obs, dout);
      end
      quiet = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (done || dout_valid || bram_en) quiet++;
      end
      checks++;
      if (quiet !== 0 || bram_rst !== 1'b0) begin
         errors++; $display("FAIL midrst_quiet got %0d active cycles rst %0b exp 0 0", quiet, bram_rst);
      end
      run_burst(0, 2, 1, 0, -1, 0);
      checks++;
      if (timed_out || words.size() !== 2 || words[0] !== 100 || words[1] !== 101) begin
         errors++; $display("FAIL midrst_new got %0d words %0d %0d exp 2 words 100 101", words.size(), words[0], words[1]);
      end
   endtask

`ifdef VRF_RD_STRIDE_EN
   task automatic test_stride();
      run_burst(0, 3, 3, 0, -1, 0);
      checks++;
      if (timed_out || words.size() !== 3) begin errors++; $display("FAIL stride_count got %0d exp 3", words.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= words.size() || words[i] !== 100 + 3 * i || iss_addr[i] !== 3 * i) begin
            errors++; $display("FAIL stride[%0d] got word %0d addr %0d exp %0d %0d", i, words[i], iss_addr[i], 100 + 3 * i, 3 * i);
         end
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'(i + 100);
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_len();
      test_reset_mid_burst();
`ifdef VRF_RD_STRIDE_EN
      test_stride();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no finish exp finish");
      $fatal(1, "watchdog");
   end

endmodule
